// File: rtl/sum_ascii_tx_if.sv
// Handshake bundle for sum_ascii_tx: the adder result comes in, and the ASCII
// character stream with its ready/valid/last handshake goes out.
interface sum_ascii_tx_if;
  logic       in_valid;
  logic [7:0] num_sum;
  logic       Cout;
  logic       in_ready;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;

  // Driver side: presents adder results and accepts characters.
  modport master (
    output in_valid, num_sum, Cout, out_ready,
    input  in_ready, out_char, out_valid, out_last, busy
  );

  // Converter side.
  modport slave (
    input  in_valid, num_sum, Cout, out_ready,
    output in_ready, out_char, out_valid, out_last, busy
  );
endinterface

// File: rtl/sum_ascii_tx.sv
// sum_ascii_tx: captures a 9-bit adder result {Cout, num_sum}, converts it to
// three BCD digits by double dabble (one bit per cycle), then streams the
// decimal digits as ASCII with leading zeros suppressed, followed by TERM_CHAR.
module sum_ascii_tx #(
  parameter logic [7:0] TERM_CHAR = 8'h0D
) (
  input logic          clk,
  input logic          rst_n,
  sum_ascii_tx_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [8:0]  shreg;    // operand bits still to be shifted into the BCD field
  logic [11:0] bcd;      // {hundreds, tens, units}
  logic [3:0]  cnt;      // 0..8 shift steps, 9 is the load cycle
  logic [1:0]  pos;      // 0 hundreds, 1 tens, 2 units, 3 terminator
  logic [7:0]  char_c;
  logic        xfer;

  // One double-dabble step: add 3 to any digit >= 5, then shift the whole
  // {bcd, operand} field left by one. Returns {bcd_next, shreg_next}.
  function automatic logic [20:0] dd_step(input logic [11:0] b, input logic [8:0] s);
    logic [11:0] a;
    a = '0;
    for (int i = 0; i < 3; i++) begin
      a[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    end
    return {a[10:0], s, 1'b0};
  endfunction

  // First character position after conversion: skip leading zero digits,
  // but the units digit is always sent.
  function automatic logic [1:0] start_pos(input logic [11:0] b);
    if (b[11:8] != 4'd0)     return 2'd0;
    else if (b[7:4] != 4'd0) return 2'd1;
    else                     return 2'd2;
  endfunction

  assign xfer = (state == SEND) && bus.out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)           state_nxt = CONV;
      CONV:    if (cnt == 4'd9)            state_nxt = SEND;
      SEND:    if (xfer && pos == 2'd3)    state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  // Operand capture, conversion steps and character pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      bcd   <= '0;
      cnt   <= '0;
      pos   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            shreg <= {bus.Cout, bus.num_sum};
            bcd   <= '0;
            cnt   <= '0;
          end
        end
        CONV: begin
          if (cnt != 4'd9) begin
            {bcd, shreg} <= dd_step(bcd, shreg);
            cnt          <= cnt + 4'd1;
          end else begin
            pos <= start_pos(bcd);
          end
        end
        SEND: begin
          if (xfer && pos != 2'd3) pos <= pos + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Character currently offered; derived from held registers so it stays
  // stable while the sink stalls.
  always_comb begin
    char_c = 8'h00;
    if (state == SEND) begin
      case (pos)
        2'd0:    char_c = 8'h30 + {4'h0, bcd[11:8]};
        2'd1:    char_c = 8'h30 + {4'h0, bcd[7:4]};
        2'd2:    char_c = 8'h30 + {4'h0, bcd[3:0]};
        default: char_c = TERM_CHAR;
      endcase
    end
  end

  assign bus.out_char  = char_c;
  assign bus.out_valid = (state == SEND);
  assign bus.out_last  = (state == SEND) && (pos == 2'd3);
  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_sum_ascii_tx.sv
// Bench for sum_ascii_tx: a table of directed conversions with out_ready held
// high, plus hand-written stall and mid-send reset sequences.
module tb_sum_ascii_tx;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;

  sum_ascii_tx_if bus ();

  sum_ascii_tx #(.TERM_CHAR(8'h0D)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cout;
    logic [7:0]  num;
    int          nch;
    logic [31:0] chars;  // first character in bits 31:24
  } vec_t;

  vec_t vt [10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string nm);
    check({nm, " in_ready"},  {31'd0, bus.in_ready},  32'd1);
    check({nm, " out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({nm, " busy"},      {31'd0, bus.busy},      32'd0);
    check({nm, " out_last"},  {31'd0, bus.out_last},  32'd0);
    check({nm, " out_char"},  {24'd0, bus.out_char},  32'h00);
  endtask

  // Accept a value, then verify the fixed 10-cycle latency.
  task automatic accept_and_wait(input logic cout, input logic [7:0] num, input string nm);
    int early;
    bus.Cout     = cout;
    bus.num_sum  = num;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check({nm, " busy after accept"}, {31'd0, bus.busy}, 32'd1);
    check({nm, " in_ready after accept"}, {31'd0, bus.in_ready}, 32'd0);
    early = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (bus.out_valid !== 1'b0) early++;
    end
    check({nm, " out_valid early"}, early, 0);
    step();
    check({nm, " out_valid at 10"}, {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic run_vec(input logic cout, input logic [7:0] num, input int nch,
                         input logic [31:0] chars, input string nm);
    logic [7:0] e;
    bus.out_ready = 1'b1;
    accept_and_wait(cout, num, nm);
    for (int i = 0; i < nch; i++) begin
      e = chars[31-8*i -: 8];
      check($sformatf("%s char%0d", nm, i), {24'd0, bus.out_char}, {24'd0, e});
      check($sformatf("%s last%0d", nm, i), {31'd0, bus.out_last}, (i == nch-1) ? 32'd1 : 32'd0);
      check($sformatf("%s valid%0d", nm, i), {31'd0, bus.out_valid}, 32'd1);
      step();
    end
    check_idle({nm, " done"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nvec = 0;
    nerr = 0;
    vt[0] = '{1'b0, 8'h00, 2, 32'h300D_0000};  //   0
    vt[1] = '{1'b0, 8'hFF, 4, 32'h3235_350D};  // 255
    vt[2] = '{1'b1, 8'hFF, 4, 32'h3531_310D};  // 511
    vt[3] = '{1'b0, 8'h64, 4, 32'h3130_300D};  // 100
    vt[4] = '{1'b0, 8'h07, 2, 32'h370D_0000};  //   7
    vt[5] = '{1'b0, 8'h69, 4, 32'h3130_350D};  // 105
    vt[6] = '{1'b0, 8'h0A, 3, 32'h3130_0D00};  //  10
    vt[7] = '{1'b1, 8'h00, 4, 32'h3235_360D};  // 256
    vt[8] = '{1'b0, 8'h63, 3, 32'h3939_0D00};  //  99
    vt[9] = '{1'b1, 8'hF4, 4, 32'h3530_300D};  // 500

    bus.in_valid  = 1'b0;
    bus.num_sum   = 8'h00;
    bus.Cout      = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    #13;
    check_idle("reset");
    step();
    rst_n = 1'b1;
    step();
    check_idle("post reset");

    for (int v = 0; v < 10; v++) begin
      run_vec(vt[v].cout, vt[v].num, vt[v].nch, vt[v].chars, $sformatf("vec%0d", v));
    end

    // 42 with the sink stalled on the first character; in_valid pulses while busy.
    bus.out_ready = 1'b0;
    accept_and_wait(1'b0, 8'h2A, "stall");
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = (k % 2 == 0);
      bus.num_sum  = 8'h11;
      check($sformatf("stall hold%0d char", k), {24'd0, bus.out_char}, 32'h34);
      check($sformatf("stall hold%0d last", k), {31'd0, bus.out_last}, 32'd0);
      check($sformatf("stall hold%0d in_ready", k), {31'd0, bus.in_ready}, 32'd0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("stall char0", {24'd0, bus.out_char}, 32'h34);
    step();
    check("stall char1", {24'd0, bus.out_char}, 32'h32);
    check("stall last1", {31'd0, bus.out_last}, 32'd0);
    step();
    check("stall char2", {24'd0, bus.out_char}, 32'h0D);
    check("stall last2", {31'd0, bus.out_last}, 32'd1);
    step();
    check_idle("stall done");

    // 255, reset pulse after the first character has been sent.
    bus.out_ready = 1'b1;
    accept_and_wait(1'b0, 8'hFF, "rst");
    check("rst char0", {24'd0, bus.out_char}, 32'h32);
    step();
    check("rst char1", {24'd0, bus.out_char}, 32'h35);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("rst async");
    step();
    rst_n = 1'b1;
    begin
      int stray;
      stray = 0;
      for (int k = 0; k < 12; k++) begin
        step();
        if (bus.out_valid !== 1'b0) stray++;
      end
      check("rst no further chars", stray, 0);
    end
    run_vec(1'b0, 8'h09, 2, 32'h390D_0000, "after rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
